vga_pixel_fetch: RTL

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 104 ++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch and output stage behind the VGA timing generator.
// Two-stage pipeline aligning frame-buffer data with delayed sync/blank.
module vga_pixel_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        h_blank,
    input  logic        v_blank,
    input  logic        v_blank_begin,
    input  logic        v_blank_end,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        disp_en,
    input  logic [7:0]  bg_color,
    input  logic        irq_ack,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        irq,
    output logic        irq_ovf,
    output logic [7:0]  frame_cnt
);

    logic       hs1_q, vs1_q, blank1_q, en_q;
    logic       hs2_q, vs2_q;
    logic [7:0] rgb_q, rgb_d;
    logic       en_d;
    logic       irq_q, irq_d;
    logic       ovf_q, ovf_d;
    logic [7:0] fc_q, fc_d;

    // Each 256-wide macropixel row covers four scan lines.
    assign mem_addr = {v_cnt[9:2], h_cnt[7:0]};
    assign mem_rd   = ~h_blank & ~v_blank;

    always_comb begin
        en_d  = en_q;
        rgb_d = 8'h00;
        irq_d = irq_q;
        ovf_d = ovf_q;
        fc_d  = fc_q;
        if (v_blank_end) begin
            en_d = disp_en;
        end
        if (!blank1_q) begin
            rgb_d = en_q ? mem_data : bg_color;
        end
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if (irq_ack && !v_blank_begin) begin
            ovf_d = 1'b0;
        end
        if (v_blank_begin) begin
            irq_d = 1'b1;
            fc_d  = fc_q + 8'd1;
        end
        if (v_blank_begin && irq_q) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            blank1_q <= 1'b1;
            en_q     <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            rgb_q    <= 8'h00;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            fc_q     <= 8'h00;
        end else begin
            hs1_q    <= h_sync;
            vs1_q    <= v_sync;
            blank1_q <= h_blank | v_blank;
            en_q     <= en_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            rgb_q    <= rgb_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            fc_q     <= fc_d;
        end
    end

    assign vga_r     = rgb_q[7:5];
    assign vga_g     = rgb_q[4:2];
    assign vga_b     = rgb_q[1:0];
    assign vga_hs    = hs2_q;
    assign vga_vs    = vs2_q;
    assign irq       = irq_q;
    assign irq_ovf   = ovf_q;
    assign frame_cnt = fc_q;

endmodule
